// File: rtl/femto_io_responder_if.sv
// Bus bundle between the CPU-side IO memory port, the PORT_A pins and the TX byte stream.
interface femto_io_responder_if;
  logic [31:0] mem_address;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;
  logic [7:0]  port_a;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mem_address, mem_wmask, mem_wdata, mem_rstrb, tx_ready,
    input  mem_rdata, mem_rbusy, mem_wbusy, port_a, tx_data, tx_valid
  );

  modport slave (
    input  mem_address, mem_wmask, mem_wdata, mem_rstrb, tx_ready,
    output mem_rdata, mem_rbusy, mem_wbusy, port_a, tx_data, tx_valid
  );
endinterface

// File: rtl/femto_io_responder.sv
// IO-space responder: PORT_A, TIMER, TX FIFO data/status; loads return one cycle after rstrb.
// TX pushes into a full FIFO park in a pending byte and raise mem_wbusy until space frees.
module femto_io_responder #(
  parameter int IO_BIT     = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  femto_io_responder_if.slave  io_bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_STALL} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_timer;
  logic [31:0]   r_rdata;
  logic [7:0]    r_port_a;
  logic [7:0]    r_pend;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic          w_sel, w_wr, w_rd, w_txw;
  logic          w_full, w_empty, w_pop, w_push;
  logic [1:0]    w_off;
  logic [7:0]    w_push_dat;
  logic [3:0]    w_cnt4;
  logic [31:0]   w_rd_dat;
  logic          w_unused;

  assign w_sel   = io_bus.mem_address[IO_BIT];
  assign w_off   = io_bus.mem_address[3:2];
  // The CPU is frozen while wbusy is high, so any store seen then is not a new request.
  assign w_wr    = w_sel & (|io_bus.mem_wmask) & (r_state == S_IDLE);
  assign w_rd    = w_sel & io_bus.mem_rstrb & ~(|io_bus.mem_wmask);
  assign w_txw   = w_wr & (w_off == 2'd2) & io_bus.mem_wmask[0];
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & io_bus.tx_ready;
  assign w_cnt4  = 4'(r_count);
  assign w_unused = &{1'b0, io_bus.mem_address, io_bus.mem_wdata};

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_dat  = io_bus.mem_wdata[7:0];
    case (r_state)
      S_IDLE: begin
        if (w_txw) begin
          if (!w_full || w_pop) w_push = 1'b1;
          else                  w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        w_push_dat = r_pend;
        if (!w_full || w_pop) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pend  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_state_nxt == S_STALL) r_pend <= io_bus.mem_wdata[7:0];
    end
  end

  always_comb begin
    w_rd_dat = 32'h0;
    case (w_off)
      2'd0: w_rd_dat = {24'h0, r_port_a};
      2'd1: w_rd_dat = r_timer;
      2'd2: w_rd_dat = 32'h0;
      2'd3: w_rd_dat = {24'h0, w_cnt4, 2'b00, w_full, w_empty};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer  <= 32'h0;
      r_rdata  <= 32'h0;
      r_port_a <= 8'h00;
    end else begin
      r_timer <= (w_wr && w_off == 2'd1) ? 32'h0 : r_timer + 32'd1;
      if (w_rd) r_rdata <= w_rd_dat;
      if (w_wr && w_off == 2'd0 && io_bus.mem_wmask[0]) r_port_a <= io_bus.mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_bus.mem_rdata = r_rdata;
  assign io_bus.mem_rbusy = 1'b0;
  assign io_bus.mem_wbusy = (r_state == S_STALL);
  assign io_bus.port_a    = r_port_a;
  assign io_bus.tx_valid  = ~w_empty;
  assign io_bus.tx_data   = w_empty ? 8'h00 : r_mem[r_rptr];
endmodule
